// File: rtl/camera_pkg.sv
// Shared definitions for the camera capture path: config field positions,
// pixel formats, capture FSM encoding and crop corner layout.
package camera_pkg;

    typedef enum logic [1:0] {
        FMT_RAW8   = 2'd0,
        FMT_16B    = 2'd1,
        FMT_16B_HI = 2'd2
    } fmt_e;

    localparam int GLOB_EN_BIT      = 31;
    localparam int GLOB_DROP_EN_BIT = 0;
    localparam int GLOB_DROP_LSB    = 1;
    localparam int GLOB_DROP_MSB    = 6;
    localparam int GLOB_CROP_EN_BIT = 7;
    localparam int GLOB_FMT_LSB     = 8;
    localparam int GLOB_FMT_MSB     = 9;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_SOF = 2'd1;
    localparam logic [1:0] ACTIVE   = 2'd2;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
    } crop_pt_t;

endpackage

// File: rtl/camera_word_fifo.sv
// Small synchronous word FIFO; head is presented combinationally so words
// stream out back to back. A push while full is only accepted alongside a pop.
module camera_word_fifo
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // When full, the write slot equals the head slot; the head is consumed this cycle.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/camera_capture_core.sv
// Camera pixel capture: frames a clk_i-synchronous byte stream, decimates and
// crops it, packs kept bytes little-endian into words and queues them for uDMA RX.
module camera_capture_core
    import camera_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [31:0] cfg_glob_i,
    input  logic [31:0] cfg_ll_i,
    input  logic [31:0] cfg_ur_i,
    input  logic        cfg_vsync_pol_i,
    input  logic        cfg_hsync_pol_i,
    input  logic [7:0]  cam_data_i,
    input  logic        cam_valid_i,
    input  logic        cam_vsync_i,
    input  logic        cam_hsync_i,
    output logic        cam_ip_en_o,
    output logic [31:0] data_rx_o,
    output logic [1:0]  data_rx_datasize_o,
    output logic        data_rx_valid_o,
    input  logic        data_rx_ready_i,
    output logic        overflow_o
);

    logic             en, drop_en, crop_en;
    logic [5:0]       drop_val;
    logic [1:0]       fmt;
    crop_pt_t         ll, ur;
    logic             unused_glob;

    logic             vs, hs, vs_q, hs_q, sof, hs_fall;
    logic [1:0]       state;
    logic [5:0]       frame_cnt;
    logic [CNT_W-1:0] x_cnt, y_cnt;
    logic             byte_phase;
    logic [1:0]       lane;
    logic [23:0]      pack_q;

    logic             active, frame_kept, byte_ok, two_byte, pixel_end;
    logic             in_window, in_crop, byte_keep, frame_end, flush_word;
    logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]      fifo_wdata;

    assign en          = cfg_glob_i[GLOB_EN_BIT];
    assign drop_en     = cfg_glob_i[GLOB_DROP_EN_BIT];
    assign drop_val    = cfg_glob_i[GLOB_DROP_MSB:GLOB_DROP_LSB];
    assign crop_en     = cfg_glob_i[GLOB_CROP_EN_BIT];
    assign fmt         = cfg_glob_i[GLOB_FMT_MSB:GLOB_FMT_LSB];
    assign ll          = cfg_ll_i;
    assign ur          = cfg_ur_i;
    assign unused_glob = ^cfg_glob_i[30:10];

    assign vs      = cam_vsync_i ^ cfg_vsync_pol_i;
    assign hs      = cam_hsync_i ^ cfg_hsync_pol_i;
    assign sof     = vs & ~vs_q;
    assign hs_fall = hs_q & ~hs;

    assign active     = (state == ACTIVE);
    assign frame_kept = ~drop_en | (frame_cnt == 6'd0);
    assign byte_ok    = active & frame_kept & cam_valid_i & hs & ~vs;
    assign two_byte   = (fmt == FMT_16B) || (fmt == FMT_16B_HI);
    assign pixel_end  = ~two_byte | byte_phase;

    assign in_window = (x_cnt >= CNT_W'(ll.x)) && (x_cnt <= CNT_W'(ur.x)) &&
                       (y_cnt >= CNT_W'(ll.y)) && (y_cnt <= CNT_W'(ur.y));
    assign in_crop   = ~crop_en | in_window;
    // In FMT_16B_HI the second byte of each pixel still advances the phase but is discarded.
    assign byte_keep = byte_ok & in_crop & ~((fmt == FMT_16B_HI) & byte_phase);

    assign frame_end  = sof & active;
    assign flush_word = frame_end & (lane != 2'd0);
    assign fifo_push  = (byte_keep & (lane == 2'd3)) | flush_word;
    assign fifo_wdata = flush_word ? {8'h00, pack_q} : {cam_data_i, pack_q};
    assign fifo_pop   = data_rx_valid_o & data_rx_ready_i;

    assign cam_ip_en_o        = active;
    assign data_rx_valid_o    = ~fifo_empty;
    assign data_rx_datasize_o = 2'b10;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vs_q <= 1'b0;
            hs_q <= 1'b0;
        end else begin
            vs_q <= vs;
            hs_q <= hs;
        end
    end

    // Enable is only honoured at frame boundaries so frames are never cut short.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:     if (en) state <= WAIT_SOF;
                WAIT_SOF: if (!en) state <= IDLE;
                          else if (sof) state <= ACTIVE;
                ACTIVE:   if (sof && !en) state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            frame_cnt <= '0;
        end else if (sof) begin
            if (!active || !drop_en || frame_cnt >= drop_val) frame_cnt <= '0;
            else frame_cnt <= frame_cnt + 6'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            byte_phase <= 1'b0;
        end else if (sof) begin
            x_cnt      <= '0;
            y_cnt      <= '0;
            byte_phase <= 1'b0;
        end else if (hs_fall) begin
            x_cnt      <= '0;
            byte_phase <= 1'b0;
            if (y_cnt != '1) y_cnt <= y_cnt + CNT_W'(1);
        end else if (byte_ok) begin
            if (two_byte) byte_phase <= ~byte_phase;
            if (pixel_end && x_cnt != '1) x_cnt <= x_cnt + CNT_W'(1);
        end
    end

    // Lane 3 never lands in pack_q: the word is pushed directly and the packer cleared.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lane   <= 2'd0;
            pack_q <= '0;
        end else if (frame_end) begin
            lane   <= 2'd0;
            pack_q <= '0;
        end else if (byte_keep) begin
            lane <= lane + 2'd1;
            case (lane)
                2'd0:    pack_q[7:0]   <= cam_data_i;
                2'd1:    pack_q[15:8]  <= cam_data_i;
                2'd2:    pack_q[23:16] <= cam_data_i;
                default: pack_q        <= '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) overflow_o <= 1'b0;
        else         overflow_o <= fifo_push & fifo_full & ~fifo_pop;
    end

    camera_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (data_rx_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_camera_capture_core.sv
// Directed bench for camera_capture_core: a per-cycle vector table for basic
// packing, then hand-written frame sequences checked against expected word lists.
module tb_camera_capture_core;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [31:0] cfg_glob_i, cfg_ll_i, cfg_ur_i;
    logic        cfg_vsync_pol_i, cfg_hsync_pol_i;
    logic [7:0]  cam_data_i;
    logic        cam_valid_i, cam_vsync_i, cam_hsync_i;
    logic        cam_ip_en_o;
    logic [31:0] data_rx_o;
    logic [1:0]  data_rx_datasize_o;
    logic        data_rx_valid_o;
    logic        data_rx_ready_i;
    logic        overflow_o;

    int n_cmp;
    int n_fail;
    logic [31:0] got_q [$];

    localparam logic [31:0] GLOB_EN = 32'h8000_0000;

    typedef struct {
        logic        vsync;
        logic        hsync;
        logic        valid;
        logic [7:0]  data;
        logic        ready;
        logic        exp_ip_en;
        logic        exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [14];

    camera_capture_core dut (
        .clk_i              (clk_i),
        .rstn_i             (rstn_i),
        .cfg_glob_i         (cfg_glob_i),
        .cfg_ll_i           (cfg_ll_i),
        .cfg_ur_i           (cfg_ur_i),
        .cfg_vsync_pol_i    (cfg_vsync_pol_i),
        .cfg_hsync_pol_i    (cfg_hsync_pol_i),
        .cam_data_i         (cam_data_i),
        .cam_valid_i        (cam_valid_i),
        .cam_vsync_i        (cam_vsync_i),
        .cam_hsync_i        (cam_hsync_i),
        .cam_ip_en_o        (cam_ip_en_o),
        .data_rx_o          (data_rx_o),
        .data_rx_datasize_o (data_rx_datasize_o),
        .data_rx_valid_o    (data_rx_valid_o),
        .data_rx_ready_i    (data_rx_ready_i),
        .overflow_o         (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Inputs only change just after a rising edge, so a word seen valid&ready here is popped next edge.
    always @(negedge clk_i) begin
        if (rstn_i && data_rx_valid_o && data_rx_ready_i) got_q.push_back(data_rx_o);
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        cam_vsync_i     = v.vsync;
        cam_hsync_i     = v.hsync;
        cam_valid_i     = v.valid;
        cam_data_i      = v.data;
        data_rx_ready_i = v.ready;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_valid_i = 1'b1;
        cam_data_i  = b;
        step();
        cam_valid_i = 1'b0;
    endtask

    task automatic send_line(input int base, input int n);
        cam_hsync_i = 1'b1;
        for (int i = 0; i < n; i++) send_byte(8'(base + i));
        cam_hsync_i = 1'b0;
        step();
    endtask

    task automatic start_frame();
        cam_vsync_i = 1'b1;
        step();
        step();
        cam_vsync_i = 1'b0;
        step();
    endtask

    task automatic check_words(input string name, input logic [31:0] exp_words [$]);
        checkOutput({name, "_count"}, 32'(got_q.size()), 32'(exp_words.size()));
        for (int i = 0; i < exp_words.size(); i++) begin
            checkOutput($sformatf("%s_word%0d", name, i),
                        (i < got_q.size()) ? got_q[i] : 32'hDEAD_BEEF, exp_words[i]);
        end
    endtask

    initial begin
        n_cmp           = 0;
        n_fail          = 0;
        rstn_i          = 1'b0;
        cfg_glob_i      = '0;
        cfg_ll_i        = '0;
        cfg_ur_i        = '0;
        cfg_vsync_pol_i = 1'b0;
        cfg_hsync_pol_i = 1'b0;
        cam_data_i      = '0;
        cam_valid_i     = 1'b0;
        cam_vsync_i     = 1'b0;
        cam_hsync_i     = 1'b0;
        data_rx_ready_i = 1'b0;

        //             vs    hs    vld   data   rdy   ip_en valid data
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 32'h0000_0000};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 32'h0403_0201};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h0403_0201};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 32'h0403_0201};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 32'h0403_0201};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h08, 1'b0, 1'b1, 1'b1, 32'h0403_0201};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h0807_0605};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0000_0000};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000};

        // Reset values
        step();
        step();
        checkOutput("reset_ip_en", 32'(cam_ip_en_o), 32'd0);
        checkOutput("reset_valid", 32'(data_rx_valid_o), 32'd0);
        checkOutput("reset_data", data_rx_o, 32'd0);
        checkOutput("reset_overflow", 32'(overflow_o), 32'd0);
        checkOutput("datasize", 32'(data_rx_datasize_o), 32'd2);
        rstn_i     = 1'b1;
        cfg_glob_i = GLOB_EN;
        step();
        checkOutput("wait_sof_ip_en", 32'(cam_ip_en_o), 32'd0);

        // Basic RAW8 packing, one line of 8 bytes, FIFO held then drained
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            step();
            checkOutput($sformatf("vec%0d_ip_en", i), 32'(cam_ip_en_o), 32'(vecs[i].exp_ip_en));
            checkOutput($sformatf("vec%0d_valid", i), 32'(data_rx_valid_o), 32'(vecs[i].exp_valid));
            checkOutput($sformatf("vec%0d_data", i), data_rx_o, vecs[i].exp_data);
        end

        // 16-bit pixels with crop window (1,1)..(2,2) over a 4x4 frame
        data_rx_ready_i = 1'b1;
        cfg_glob_i      = GLOB_EN | 32'h0000_0180;
        cfg_ll_i        = 32'h0001_0001;
        cfg_ur_i        = 32'h0002_0002;
        got_q.delete();
        start_frame();
        for (int y = 0; y < 4; y++) send_line(y * 16, 8);
        start_frame();
        check_words("crop", '{32'h1514_1312, 32'h2524_2322});

        // Frame decimation keeping 1 of 3, starting fresh
        rstn_i = 1'b0;
        step();
        rstn_i     = 1'b1;
        cfg_glob_i = GLOB_EN | 32'h0000_0005;
        step();
        got_q.delete();
        for (int f = 0; f < 6; f++) begin
            start_frame();
            send_line(f * 16, 4);
        end
        start_frame();
        check_words("drop", '{32'h0302_0100, 32'h3332_3130});

        // Partial word flushed zero-padded at next SOF
        cfg_glob_i = GLOB_EN;
        got_q.delete();
        start_frame();
        send_line(1, 5);
        start_frame();
        step();
        check_words("partial", '{32'h0403_0201, 32'h0000_0005});

        // FIFO overflow with ready low, then push+pop while full
        got_q.delete();
        data_rx_ready_i = 1'b0;
        cam_hsync_i     = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            if (k == 24) data_rx_ready_i = 1'b1;
            send_byte(8'(k));
            if (k == 16) checkOutput("ovf_before_full", 32'(overflow_o), 32'd0);
            if (k == 20) checkOutput("ovf_pulse", 32'(overflow_o), 32'd1);
            if (k == 21) checkOutput("ovf_one_cycle", 32'(overflow_o), 32'd0);
            if (k == 24) checkOutput("ovf_push_pop_full", 32'(overflow_o), 32'd0);
        end
        cam_hsync_i = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_words("overflow", '{32'h0403_0201, 32'h0807_0605, 32'h0C0B_0A09,
                                  32'h100F_0E0D, 32'h1817_1615});

        // Enable cleared mid-frame: frame completes, capture stops at next SOF
        start_frame();
        got_q.delete();
        cam_hsync_i = 1'b1;
        send_byte(8'hA1);
        send_byte(8'hA2);
        cfg_glob_i = 32'h0;
        checkOutput("en_off_still_running", 32'(cam_ip_en_o), 32'd1);
        send_byte(8'hA3);
        cam_hsync_i = 1'b0;
        step();
        checkOutput("en_off_before_sof", 32'(cam_ip_en_o), 32'd1);
        start_frame();
        checkOutput("en_off_after_sof", 32'(cam_ip_en_o), 32'd0);
        step();
        check_words("en_off_flush", '{32'h00A3_A2A1});

        // Active-low vsync: SOF is the falling edge of cam_vsync_i
        cam_vsync_i     = 1'b1;
        cfg_vsync_pol_i = 1'b1;
        cfg_glob_i      = GLOB_EN;
        step();
        step();
        step();
        checkOutput("vpol_idle_high", 32'(cam_ip_en_o), 32'd0);
        cam_vsync_i = 1'b0;
        step();
        checkOutput("vpol_sof_fall", 32'(cam_ip_en_o), 32'd1);
        cam_vsync_i = 1'b1;
        step();
        got_q.delete();
        send_line(8'hB0, 4);
        step();
        check_words("vpol_line", '{32'hB3B2_B1B0});
        cam_vsync_i     = 1'b0;
        cfg_vsync_pol_i = 1'b0;
        step();

        // Asynchronous reset mid-line
        data_rx_ready_i = 1'b0;
        start_frame();
        got_q.delete();
        cam_hsync_i = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i));
        checkOutput("pre_reset_valid", 32'(data_rx_valid_o), 32'd1);
        checkOutput("pre_reset_data", data_rx_o, 32'hC3C2_C1C0);
        send_byte(8'hC4);
        send_byte(8'hC5);
        rstn_i = 1'b0;
        #1;
        checkOutput("async_reset_valid", 32'(data_rx_valid_o), 32'd0);
        checkOutput("async_reset_ip_en", 32'(cam_ip_en_o), 32'd0);
        checkOutput("async_reset_data", data_rx_o, 32'd0);
        step();
        rstn_i          = 1'b1;
        data_rx_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hD0 + i));
        cam_hsync_i = 1'b0;
        step();
        checkOutput("post_reset_no_words", 32'(got_q.size()), 32'd0);
        checkOutput("post_reset_valid", 32'(data_rx_valid_o), 32'd0);
        checkOutput("post_reset_ip_en", 32'(cam_ip_en_o), 32'd0);
        start_frame();
        checkOutput("restart_ip_en", 32'(cam_ip_en_o), 32'd1);
        send_line(8'hE0, 4);
        step();
        check_words("restart", '{32'hE3E2_E1E0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
